// File: rtl/credit_tx.sv
// rtl/credit_tx.sv - transmit-side credit owner for the CDC credit buffer
//
// Purpose:
//   Accepts words from a local valid/ready producer. Each accepted word is
//   written into the CDC buffer as a one-cycle re_valid/re_data strobe, and
//   one credit is spent for it. Each re_credit_pulse from the buffer restores
//   one credit. A quiesce handshake stops new sends, waits until every credit
//   is home, and then acknowledges.
//
// Ports:
//   re_clk           sole clock (buffer write-side clock)
//   re_reset         synchronous, active-high reset
//   src_valid        producer has a word
//   src_data         producer word
//   src_ready        word accepted this cycle when src_valid && src_ready
//   re_valid         one-cycle write strobe to the buffer
//   re_data          word written into the buffer (holds between strobes)
//   re_credit_pulse  one-cycle credit return from the buffer
//   quiesce_req      level request: stop sending and drain credits
//   quiesce_ack      high while idle (all credits home, no sends)
//   credits_avail    current credit count
//   credit_err       sticky: credit returned while the count was already full
module credit_tx #(
   parameter int WIDTH   = 32,
   parameter int CREDITS = 16,
   parameter int CNT_W   = $clog2(CREDITS + 1)
) (
   input  logic             re_clk,
   input  logic             re_reset,
   input  logic             src_valid,
   input  logic [WIDTH-1:0] src_data,
   output logic             src_ready,
   output logic             re_valid,
   output logic [WIDTH-1:0] re_data,
   input  logic             re_credit_pulse,
   input  logic             quiesce_req,
   output logic             quiesce_ack,
   output logic [CNT_W-1:0] credits_avail,
   output logic             credit_err
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      IDLE  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDITS);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] credits;
   logic             ack_q;
   logic             err_q;
   logic             fire;
   logic             full;

   assign full = (credits == FULL);

   // Derived from registers only, so the producer never sees a combinational
   // path from its own src_valid back to src_ready.
   assign src_ready = (state == RUN) && (credits != '0);
   assign fire      = src_valid && src_ready;

   assign quiesce_ack   = ack_q;
   assign credits_avail = credits;
   assign credit_err    = err_q;

   always_comb begin
      state_nx = state;
      case (state)
         RUN: begin
            if (quiesce_req) state_nx = DRAIN;
         end
         DRAIN: begin
            // A withdrawn request wins over reaching full credits.
            if (!quiesce_req)  state_nx = RUN;
            else if (full)     state_nx = IDLE;
         end
         IDLE: begin
            if (!quiesce_req) state_nx = RUN;
         end
         default: state_nx = RUN;
      endcase
   end

   always_ff @(posedge re_clk) begin
      if (re_reset) begin
         state    <= RUN;
         credits  <= FULL;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         re_valid <= 1'b0;
         re_data  <= '0;
      end else begin
         state    <= state_nx;
         // Registered ack tracks the state register exactly.
         ack_q    <= (state_nx == IDLE);
         re_valid <= fire;
         if (fire) re_data <= src_data;

         // fire implies credits != 0, and increments are blocked at FULL,
         // so the counter can never wrap.
         if (fire && !re_credit_pulse) begin
            credits <= credits - ONE;
         end else if (re_credit_pulse && !fire) begin
            if (full) err_q   <= 1'b1;
            else      credits <= credits + ONE;
         end
      end
   end

endmodule

// File: tb/tb_credit_tx.sv
// tb/tb_credit_tx.sv - randomized self-checking bench for credit_tx
module tb_credit_tx;

   localparam int WIDTH   = 32;
   localparam int CREDITS = 16;
   localparam int CNT_W   = $clog2(CREDITS + 1);

   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_IDLE  = 2;

   logic             clk = 1'b0;
   logic             re_reset;
   logic             src_valid;
   logic [WIDTH-1:0] src_data;
   logic             src_ready;
   logic             re_valid;
   logic [WIDTH-1:0] re_data;
   logic             re_credit_pulse;
   logic             quiesce_req;
   logic             quiesce_ack;
   logic [CNT_W-1:0] credits_avail;
   logic             credit_err;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          m_credits;
   int          m_mode;
   bit          m_err;
   bit          m_valid;
   logic [31:0] m_data;
   bit          m_known = 0;
   int          strobes;

   always #5 clk = ~clk;

   credit_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
      .re_clk          (clk),
      .re_reset        (re_reset),
      .src_valid       (src_valid),
      .src_data        (src_data),
      .src_ready       (src_ready),
      .re_valid        (re_valid),
      .re_data         (re_data),
      .re_credit_pulse (re_credit_pulse),
      .quiesce_req     (quiesce_req),
      .quiesce_ack     (quiesce_ack),
      .credits_avail   (credits_avail),
      .credit_err      (credit_err)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle with the currently driven inputs. Checks src_ready before
   // the edge, advances the model at the edge, checks registered outputs after.
   task automatic cycle();
      bit m_ready;
      bit fire;
      int old_credits;
      m_ready = (m_mode == M_RUN) && (m_credits > 0);
      if (m_known) check("src_ready", src_ready, m_ready);
      @(posedge clk);
      if (re_reset) begin
         m_credits = CREDITS;
         m_mode    = M_RUN;
         m_err     = 0;
         m_valid   = 0;
         m_data    = '0;
         m_known   = 1;
      end else begin
         fire        = src_valid && m_ready;
         old_credits = m_credits;
         m_valid     = fire;
         if (fire) m_data = src_data;
         if (fire && !re_credit_pulse)      m_credits = m_credits - 1;
         else if (re_credit_pulse && !fire) begin
            if (m_credits == CREDITS) m_err = 1;
            else                      m_credits = m_credits + 1;
         end
         if (m_mode == M_RUN && quiesce_req)           m_mode = M_DRAIN;
         else if (m_mode == M_DRAIN && !quiesce_req)   m_mode = M_RUN;
         else if (m_mode == M_DRAIN && old_credits == CREDITS) m_mode = M_IDLE;
         else if (m_mode == M_IDLE && !quiesce_req)    m_mode = M_RUN;
      end
      #1;
      if (re_valid) strobes++;
      check("re_valid", re_valid, m_valid);
      check("re_data", re_data, m_data);
      check("credits_avail", credits_avail, m_credits);
      check("quiesce_ack", quiesce_ack, m_mode == M_IDLE);
      check("credit_err", credit_err, m_err);
   endtask

   task automatic drive(input bit v, input bit p, input bit q, input bit r);
      re_reset        = r;
      src_valid       = v;
      src_data        = $urandom;
      re_credit_pulse = p;
      quiesce_req     = q;
   endtask

   initial begin
      drive(0, 0, 0, 1);
      cycle();
      cycle();
      check("rst_credits", credits_avail, CREDITS);
      check("rst_valid", re_valid, 0);
      check("rst_err", credit_err, 0);
      check("rst_ack", quiesce_ack, 0);
      check("rst_ready", src_ready, 1);

      // 1: continuous producer, no pulses -> 16 strobes then stall
      strobes = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 0, 0);
         cycle();
      end
      check("t1_strobes", strobes, 16);
      check("t1_ready", src_ready, 0);
      check("t1_credits", credits_avail, 0);

      // 2: three pulses from empty, then three strobes
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 0, 0);
         cycle();
         if (i == 0) check("t2_ready_after_pulse", src_ready, 1);
      end
      check("t2_credits", credits_avail, 3);
      strobes = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 0, 0);
         cycle();
      end
      check("t2_strobes", strobes, 3);

      // 3: fire and pulse in the same cycle at credits=5
      for (int i = 0; i < 5; i++) begin
         drive(0, 1, 0, 0);
         cycle();
      end
      drive(1, 1, 0, 0);
      cycle();
      check("t3_credits", credits_avail, 5);
      check("t3_valid", re_valid, 1);

      // 4: bring to 12 (4 out), quiesce, drain, release
      for (int i = 0; i < 7; i++) begin
         drive(0, 1, 0, 0);
         cycle();
      end
      drive(1, 0, 1, 0);
      cycle();
      check("t4_credits_at_req", credits_avail, 11);
      check("t4_ready_drain", src_ready, 0);
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 1, 0);
         cycle();
      end
      drive(1, 0, 1, 0);
      cycle();
      check("t4_ack", quiesce_ack, 1);
      check("t4_full", credits_avail, 16);
      drive(0, 0, 0, 0);
      cycle();
      check("t4_ack_drop", quiesce_ack, 0);
      check("t4_ready_run", src_ready, 1);

      // 5: stray pulse when full -> sticky error
      drive(0, 1, 0, 0);
      cycle();
      check("t5_credits", credits_avail, 16);
      check("t5_err", credit_err, 1);
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0);
         cycle();
      end
      check("t5_err_sticky", credit_err, 1);

      // 6: reset mid-burst at credits=7
      drive(0, 0, 0, 1);
      cycle();
      while (m_credits > 7) begin
         drive(1, 0, 0, 0);
         cycle();
      end
      check("t6_pre", credits_avail, 7);
      drive(1, 0, 0, 1);
      cycle();
      check("t6_credits", credits_avail, 16);
      check("t6_valid", re_valid, 0);
      check("t6_err", credit_err, 0);
      check("t6_ready", src_ready, 1);

      // random traffic against the model
      begin
         bit q;
         q = 0;
         for (int i = 0; i < 3000; i++) begin
            bit v, p;
            v = ($urandom_range(0, 3) != 0);
            p = (m_credits < CREDITS) ? ($urandom_range(0, 2) == 0)
                                      : ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 40) == 0) q = ~q;
            drive(v, p, q, $urandom_range(0, 400) == 0);
            cycle();
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
